serializer_piso: RTL and testbench

SERIALIZER_PISO -- requirements
Module: serializer_piso

---
 rtl/serializer_piso.sv | 115 +++++++++++
 tb/tb_serializer_piso.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/serializer_piso.sv
// Parallel-in serial-out shifter with valid/ready load handshake and frame strobes.
// Supports back-to-back frames by reloading on the last bit of the current frame.
module serializer_piso #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_end_q, frame_end_d;
  logic             last_bit;
  logic             hs;

  assign last_bit   = (cnt_q == CNT_MAX);
  assign load_ready = !reset && ((state_q == IDLE) || last_bit);
  assign hs         = load_valid && load_ready;

  // State, counter and shift register register bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      shreg_q       <= '0;
      sout_q        <= 1'b0;
      sout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shreg_q       <= shreg_d;
      sout_q        <= sout_d;
      sout_valid_q  <= sout_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
    end
  end

  // Next-state logic; outputs are precomputed from the next state so they leave flops
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shreg_d       = shreg_q;
    sout_d        = 1'b0;
    sout_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = load_data;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          cnt_d = '0;
          if (hs) begin
            shreg_d = load_data;
          end else begin
            state_d = IDLE;
            shreg_d = '0;
          end
        end else begin
          cnt_d   = cnt_q + CW'(1);
          shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        shreg_d = '0;
      end
    endcase

    if (state_d == SHIFT) begin
      sout_d        = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
      sout_valid_d  = 1'b1;
      frame_start_d = (cnt_d == '0);
      frame_end_d   = (cnt_d == CNT_MAX);
    end
  end

  assign sout        = sout_q;
  assign sout_valid  = sout_valid_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign busy        = (state_q == SHIFT);

endmodule

// File: tb/tb_serializer_piso.sv
// Directed and randomized checks of serializer_piso, LSB-first and MSB-first instances side by side.
module tb_serializer_piso;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid;
  logic [7:0] load_data;

  logic l_load_ready, l_sout, l_sout_valid, l_frame_start, l_frame_end, l_busy;
  logic m_load_ready, m_sout, m_sout_valid, m_frame_start, m_frame_end, m_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serializer_piso #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(l_load_ready), .sout(l_sout), .sout_valid(l_sout_valid),
    .frame_start(l_frame_start), .frame_end(l_frame_end), .busy(l_busy)
  );

  serializer_piso #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(m_load_ready), .sout(m_sout), .sout_valid(m_sout_valid),
    .frame_start(m_frame_start), .frame_end(m_frame_end), .busy(m_busy)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; load_valid = 1'b0; load_data = 8'h00;
    @(negedge clk);
    total++; if (l_sout_valid !== 1'b0) begin bad++; $display("FAIL rst_sout_valid got=%b exp=0", l_sout_valid); end
    total++; if (l_sout !== 1'b0) begin bad++; $display("FAIL rst_sout got=%b exp=0", l_sout); end
    total++; if (l_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", l_busy); end
    total++; if (l_load_ready !== 1'b0) begin bad++; $display("FAIL rst_load_ready got=%b exp=0", l_load_ready); end
    total++; if ({l_frame_start, l_frame_end} !== 2'b00) begin bad++; $display("FAIL rst_strobes got=%b exp=00", {l_frame_start, l_frame_end}); end
    reset = 1'b0;
    #1;
    total++; if (l_load_ready !== 1'b1) begin bad++; $display("FAIL rel_load_ready got=%b exp=1", l_load_ready); end
  endtask

  task automatic test_single_frame;
    bit exp_l [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bit exp_m [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    load_valid = 1'b1; load_data = 8'hC1;
    tick;
    load_valid = 1'b0; load_data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      total++; if (l_sout !== exp_l[i]) begin bad++; $display("FAIL single_lsb_sout cyc%0d got=%b exp=%b", i + 1, l_sout, exp_l[i]); end
      total++; if (m_sout !== exp_m[i]) begin bad++; $display("FAIL single_msb_sout cyc%0d got=%b exp=%b", i + 1, m_sout, exp_m[i]); end
      total++; if (l_sout_valid !== 1'b1 || l_busy !== 1'b1) begin bad++; $display("FAIL single_valid_busy cyc%0d got=%b%b exp=11", i + 1, l_sout_valid, l_busy); end
      total++; if (l_frame_start !== 1'(i == 0) || m_frame_start !== 1'(i == 0)) begin bad++; $display("FAIL single_frame_start cyc%0d got=%b%b exp=%b", i + 1, l_frame_start, m_frame_start, 1'(i == 0)); end
      total++; if (l_frame_end !== 1'(i == 7) || m_frame_end !== 1'(i == 7)) begin bad++; $display("FAIL single_frame_end cyc%0d got=%b%b exp=%b", i + 1, l_frame_end, m_frame_end, 1'(i == 7)); end
      total++; if (l_load_ready !== 1'(i == 7)) begin bad++; $display("FAIL single_load_ready cyc%0d got=%b exp=%b", i + 1, l_load_ready, 1'(i == 7)); end
      tick;
    end
    total++; if ({l_sout_valid, l_sout, l_frame_start, l_frame_end, l_busy} !== 5'b0) begin bad++; $display("FAIL single_after got=%b exp=00000", {l_sout_valid, l_sout, l_frame_start, l_frame_end, l_busy}); end
    total++; if (m_sout_valid !== 1'b0) begin bad++; $display("FAIL single_after_msb got=%b exp=0", m_sout_valid); end
  endtask

  task automatic test_back_to_back;
    bit exp_l [16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bit exp_m [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    load_valid = 1'b1; load_data = 8'h01;
    tick;
    load_data = 8'h80;
    for (int i = 0; i < 16; i++) begin
      total++; if (l_sout !== exp_l[i]) begin bad++; $display("FAIL b2b_lsb_sout cyc%0d got=%b exp=%b", i + 1, l_sout, exp_l[i]); end
      total++; if (m_sout !== exp_m[i]) begin bad++; $display("FAIL b2b_msb_sout cyc%0d got=%b exp=%b", i + 1, m_sout, exp_m[i]); end
      total++; if (l_sout_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid cyc%0d got=%b exp=1", i + 1, l_sout_valid); end
      total++; if (l_frame_start !== 1'(i == 0 || i == 8)) begin bad++; $display("FAIL b2b_frame_start cyc%0d got=%b exp=%b", i + 1, l_frame_start, 1'(i == 0 || i == 8)); end
      total++; if (l_frame_end !== 1'(i == 7 || i == 15)) begin bad++; $display("FAIL b2b_frame_end cyc%0d got=%b exp=%b", i + 1, l_frame_end, 1'(i == 7 || i == 15)); end
      if (i == 15) load_valid = 1'b0;
      tick;
    end
    total++; if (l_sout_valid !== 1'b0 || l_busy !== 1'b0) begin bad++; $display("FAIL b2b_after got=%b%b exp=00", l_sout_valid, l_busy); end
  endtask

  task automatic test_ignore_while_busy;
    bit exp_l [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    load_valid = 1'b1; load_data = 8'h5A;
    tick;
    for (int i = 0; i < 8; i++) begin
      total++; if (l_sout !== exp_l[i]) begin bad++; $display("FAIL ignore_sout cyc%0d got=%b exp=%b", i + 1, l_sout, exp_l[i]); end
      total++; if (l_load_ready !== 1'(i == 7)) begin bad++; $display("FAIL ignore_load_ready cyc%0d got=%b exp=%b", i + 1, l_load_ready, 1'(i == 7)); end
      if (i < 7) begin
        load_valid = 1'b1; load_data = 8'(i * 37 + 3);
      end else begin
        load_valid = 1'b0;
      end
      tick;
    end
    total++; if (l_sout_valid !== 1'b0) begin bad++; $display("FAIL ignore_after got=%b exp=0", l_sout_valid); end
  endtask

  task automatic test_reset_mid_frame;
    bit exp_l [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    load_valid = 1'b1; load_data = 8'hFF;
    tick;
    load_valid = 1'b0; load_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      total++; if (l_sout !== 1'b1) begin bad++; $display("FAIL midrst_pre_sout cyc%0d got=%b exp=1", i + 1, l_sout); end
      if (i < 2) tick;
    end
    #2 reset = 1'b1;
    #1;
    total++; if ({l_sout, l_sout_valid, l_busy, l_frame_start, l_frame_end} !== 5'b0) begin bad++; $display("FAIL midrst_async got=%b exp=00000", {l_sout, l_sout_valid, l_busy, l_frame_start, l_frame_end}); end
    total++; if (l_load_ready !== 1'b0 || m_sout_valid !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b%b exp=00", l_load_ready, m_sout_valid); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (l_load_ready !== 1'b1 || l_sout_valid !== 1'b0) begin bad++; $display("FAIL midrst_release got=%b%b exp=10", l_load_ready, l_sout_valid); end
    load_valid = 1'b1; load_data = 8'h3C;
    tick;
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++; if (l_sout !== exp_l[i] || l_sout_valid !== 1'b1) begin bad++; $display("FAIL midrst_new_frame cyc%0d got=%b%b exp=%b1", i + 1, l_sout, l_sout_valid, exp_l[i]); end
      total++; if (l_frame_start !== 1'(i == 0)) begin bad++; $display("FAIL midrst_frame_start cyc%0d got=%b exp=%b", i + 1, l_frame_start, 1'(i == 0)); end
      tick;
    end
    total++; if (l_sout_valid !== 1'b0) begin bad++; $display("FAIL midrst_after got=%b exp=0", l_sout_valid); end
  endtask

  task automatic test_random;
    logic [7:0] q [$];
    logic [7:0] wl, wm, exp_w;
    int idx, frames;
    idx = 0; frames = 0; wl = '0; wm = '0;
    load_valid = 1'b0;
    for (int c = 0; c < 330; c++) begin
      tick;
      if (l_sout_valid) begin
        if (l_frame_start) idx = 0;
        if (idx < 8) wl[idx] = l_sout;
        wm = {wm[6:0], m_sout};
        idx++;
        if (l_frame_end) begin
          frames++;
          exp_w = (q.size() != 0) ? q.pop_front() : 8'hxx;
          total++; if (wl !== exp_w || idx != 8) begin bad++; $display("FAIL rand_lsb_frame %0d got=%h bits=%0d exp=%h", frames, wl, idx, exp_w); end
          total++; if (wm !== exp_w) begin bad++; $display("FAIL rand_msb_frame %0d got=%h exp=%h", frames, wm, exp_w); end
        end
      end
      total++; if (l_busy !== l_sout_valid || m_busy !== m_sout_valid) begin bad++; $display("FAIL rand_busy cyc%0d got=%b%b exp=%b%b", c, l_busy, m_busy, l_sout_valid, m_sout_valid); end
      if (c < 300) begin
        load_valid = ($urandom_range(0, 3) != 0);
        load_data  = 8'($urandom);
      end else begin
        load_valid = 1'b0;
      end
      if (load_valid && l_load_ready) q.push_back(load_data);
    end
    total++; if (q.size() != 0) begin bad++; $display("FAIL rand_leftover got=%0d exp=0", q.size()); end
    total++; if (frames < 10) begin bad++; $display("FAIL rand_frame_count got=%0d exp>=10", frames); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ignore_while_busy();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
